// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: in-order RAW hazard detection with an internal in-flight writer scoreboard
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 3,
  parameter int PIPE_DEPTH = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_dest,
  input  logic                          id_wb_en,
  input  logic                          id_mem_r_en,
  input  logic                          id_is_branch,
  input  logic                          forward_en,
  input  logic                          flush,
  output logic                          hazard_detected,
  output logic                          inflight_busy,
  output logic [CNT_W-1:0]              stall_cnt
);
  logic [PIPE_DEPTH-1:0]                 wb_q, wb_d, mr_q, mr_d;
  logic [PIPE_DEPTH-1:0][REG_ADDR_W-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]                      stall_cnt_q, stall_cnt_d;
  logic                                  raw, load_raw, issue;
  always_comb begin
    raw = 1'b0;
    load_raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int k = 0; k < PIPE_DEPTH; k++)
        if (id_src_used[i] && wb_q[k] && id_src[i*REG_ADDR_W +: REG_ADDR_W] == dest_q[k]) begin
          raw = 1'b1;
          if (k < LOAD_LAT && mr_q[k]) load_raw = 1'b1;
        end
  end
  assign hazard_detected = id_valid & ~flush & (forward_en ? (load_raw | (id_is_branch & raw)) : raw);
  assign issue = id_valid & ~flush & ~hazard_detected;
  // Entry 0 takes the issuing instruction or a bubble; older entries age by one stage.
  always_comb begin
    wb_d = '0;
    mr_d = '0;
    dest_d = '0;
    wb_d[0] = issue & id_wb_en;
    mr_d[0] = issue & id_mem_r_en;
    dest_d[0] = issue ? id_dest : '0;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      wb_d[k] = wb_q[k-1];
      mr_d[k] = mr_q[k-1];
      dest_d[k] = dest_q[k-1];
    end
  end
  assign stall_cnt_d = (hazard_detected && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_q <= '0;
      mr_q <= '0;
      dest_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      wb_q <= wb_d;
      mr_q <= mr_d;
      dest_q <= dest_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign inflight_busy = |wb_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed checks of stalls, forwarding, flush, reset and counter saturation
module tb_hazard_scoreboard_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_wb_en, id_mem_r_en, id_is_branch, forward_en, flush;
  logic [11:0] id_src;
  logic [2:0]  id_src_used;
  logic [3:0]  id_dest;
  logic        haz, busy, sat_haz, sat_busy;
  logic [15:0] cnt;
  logic [1:0]  sat_cnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_scoreboard_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_is_branch(id_is_branch),
    .forward_en(forward_en), .flush(flush), .hazard_detected(haz), .inflight_busy(busy), .stall_cnt(cnt)
  );
  hazard_scoreboard_unit #(.PIPE_DEPTH(5), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_is_branch(id_is_branch),
    .forward_en(forward_en), .flush(flush), .hazard_detected(sat_haz), .inflight_busy(sat_busy), .stall_cnt(sat_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_in(input logic v, input logic [3:0] s2, input logic [3:0] s1, input logic [3:0] s0,
                        input logic [2:0] used, input logic [3:0] dest, input logic wb, input logic mr,
                        input logic br, input logic fl);
    id_valid = v;
    id_src = {s2, s1, s0};
    id_src_used = used;
    id_dest = dest;
    id_wb_en = wb;
    id_mem_r_en = mr;
    id_is_branch = br;
    flush = fl;
    #1;
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic drain();
    set_in(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    tick();
    tick();
  endtask
  initial begin
    rst = 1'b0;
    forward_en = 1'b0;
    set_in(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    #1;
    chk("reset_haz", haz, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cnt", cnt, 0);
    tick();
    rst = 1'b1;
    set_in(1, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0);
    chk("first_cycle_haz_dest0", haz, 0);
    tick();
    // No forwarding: writer then immediate reader stalls PIPE_DEPTH cycles
    set_in(1, 0, 0, 3, 3'b001, 3, 1, 0, 0, 0);
    chk("t1_self_src_dest", haz, 0);
    tick();
    set_in(1, 0, 0, 3, 3'b001, 4, 1, 0, 0, 0);
    chk("t1_stall0", haz, 1);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_stall1", haz, 1);
    chk("t1_cnt1", cnt, 1);
    tick();
    chk("t1_release", haz, 0);
    chk("t1_cnt2", cnt, 2);
    tick();
    drain();
    chk("t1_drained", busy, 0);
    // Forwarding: ALU producer free, load producer one stall
    forward_en = 1'b1;
    set_in(1, 0, 0, 0, 3'b001, 3, 1, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 3, 3'b001, 4, 1, 0, 0, 0);
    chk("t2_alu_fwd", haz, 0);
    tick();
    drain();
    chk("t2_cnt", cnt, 2);
    set_in(1, 0, 0, 0, 3'b001, 3, 1, 1, 0, 0);
    tick();
    set_in(1, 0, 3, 0, 3'b010, 4, 1, 0, 0, 0);
    chk("t2_load_stall", haz, 1);
    tick();
    chk("t2_load_release", haz, 0);
    chk("t2_load_cnt", cnt, 3);
    tick();
    drain();
    // Branch consumer resolves in ID and cannot use forwarding
    set_in(1, 0, 0, 0, 3'b001, 5, 1, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 5, 3'b001, 0, 0, 0, 1, 0);
    chk("t3_br_stall0", haz, 1);
    tick();
    chk("t3_br_stall1", haz, 1);
    tick();
    chk("t3_br_release", haz, 0);
    chk("t3_cnt", cnt, 5);
    tick();
    drain();
    set_in(1, 0, 0, 0, 3'b001, 5, 1, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 5, 3'b001, 0, 0, 0, 0, 0);
    chk("t3_nonbr", haz, 0);
    tick();
    drain();
    // Unused source must not match
    forward_en = 1'b0;
    set_in(1, 0, 0, 0, 3'b001, 9, 1, 0, 0, 0);
    tick();
    set_in(1, 9, 1, 2, 3'b011, 0, 0, 0, 0, 0);
    chk("t4_src2_unused", haz, 0);
    tick();
    drain();
    set_in(1, 0, 0, 0, 3'b001, 9, 1, 0, 0, 0);
    tick();
    set_in(1, 9, 1, 2, 3'b111, 0, 0, 0, 0, 0);
    chk("t4_src2_used", haz, 1);
    tick();
    drain();
    chk("t4_cnt", cnt, 6);
    // Flush masks the hazard and keeps the flushed writer out of the scoreboard
    set_in(1, 0, 0, 0, 3'b001, 7, 1, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 7, 3'b001, 8, 1, 0, 0, 1);
    chk("t5_flush_haz", haz, 0);
    tick();
    set_in(1, 0, 0, 8, 3'b001, 0, 0, 0, 0, 0);
    chk("t5_flushed_dest", haz, 0);
    chk("t5_busy", busy, 1);
    tick();
    drain();
    chk("t5_cnt", cnt, 6);
    // Asynchronous reset during a stall
    set_in(1, 0, 0, 0, 3'b001, 3, 1, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 3, 3'b001, 0, 0, 0, 0, 0);
    chk("t6_pre_haz", haz, 1);
    chk("t6_pre_cnt", cnt, 6);
    rst = 1'b0;
    #1;
    chk("t6_rst_haz", haz, 0);
    chk("t6_rst_cnt", cnt, 0);
    chk("t6_rst_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    drain();
    // Saturation with CNT_W=2 over a 5-cycle stall
    set_in(1, 0, 0, 0, 3'b001, 3, 1, 0, 0, 0);
    tick();
    set_in(1, 0, 0, 3, 3'b001, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("sat_haz", sat_haz, 1);
      tick();
      chk("sat_cnt", sat_cnt, (i + 1 > 3) ? 3 : i + 1);
    end
    chk("sat_release", sat_haz, 0);
    chk("sat_main_cnt", cnt, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
